spi_xfer_queue: RTL and testbench

//  Upstream feeder for the SPI master. Buffers host bytes in a TX FIFO and

---
 rtl/spi_xfer_queue_if.sv | 33 +++
 rtl/spi_xfer_queue.sv | 178 +++++++++++++++++
 tb/tb_spi_xfer_queue.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_queue_if.sv
// spi_xfer_queue_if: host-side and SPI-master-side signal bundle.
// slave = queue side (the block itself), master = host + SPI master side.
interface spi_xfer_queue_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  WrEn;
   logic [DATA_WIDTH-1:0] WrData;
   logic                  TxFull;
   logic                  RdEn;
   logic [DATA_WIDTH-1:0] RdData;
   logic                  RxEmpty;
   logic                  Busy;
   logic                  TxOvf;
   logic                  RxOvf;
   logic                  Timeout;
   logic                  ClrErr;
   logic                  MStart;
   logic [DATA_WIDTH-1:0] MTxData;
   logic                  MDone;
   logic [DATA_WIDTH-1:0] MRxData;

   modport slave (
      input  WrEn, WrData, RdEn, ClrErr, MDone, MRxData,
      output TxFull, RdData, RxEmpty, Busy, TxOvf, RxOvf,
      output Timeout, MStart, MTxData
   );

   modport master (
      output WrEn, WrData, RdEn, ClrErr, MDone, MRxData,
      input  TxFull, RdData, RxEmpty, Busy, TxOvf, RxOvf,
      input  Timeout, MStart, MTxData
   );
endinterface

// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue: TX FIFO -> one SPI master transfer per byte -> RX FIFO.
// Ports: Clk, Reset_n (async, low), bus (spi_xfer_queue_if.slave):
//   host WrEn/WrData/TxFull, RdEn/RdData/RxEmpty, Busy, sticky
//   TxOvf/RxOvf/Timeout + ClrErr; master MStart/MTxData/MDone/MRxData.
// Optional watchdog: define SPI_XFER_TIMEOUT_EN.
module spi_xfer_queue #(
   parameter int DATA_WIDTH     = 8,
   parameter int FIFO_AW        = 2,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic             Clk,
   input logic             Reset_n,
   spi_xfer_queue_if.slave bus
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST =
      GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      IDLE, LOAD, WAIT_ACK, WAIT_DONE, GAP
   } state_t;

   localparam state_t POST = (GAP_CYCLES == 0) ? IDLE : GAP;

   state_t state_q, state_n;

   logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
   logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
   logic [FIFO_AW:0]      tx_wp, tx_rp, rx_wp, rx_rp;
   logic [FIFO_AW:0]      rx_wp_nx, rx_rp_nx;
   logic                  tx_empty, tx_full, rx_empty, rx_full;
   logic                  tx_push, tx_pop, rx_push, rx_pop;
   logic                  push_n, to_set, wd_fire;
   logic                  rx_push_q;
   logic [DATA_WIDTH-1:0] rx_word_q, rd_q, rd_nx, mtx_q;
   logic                  mstart_q, tx_ovf_q, rx_ovf_q, to_q;
   logic [GW-1:0]         gap_q;

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                     (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                     (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);

   // A pop in the same cycle frees the slot, so a push on full is taken.
   assign tx_push = bus.WrEn && (!tx_full || tx_pop);
   assign rx_pop  = bus.RdEn && !rx_empty;
   assign rx_push = rx_push_q && (!rx_full || rx_pop);

`ifdef SPI_XFER_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
   logic [WW-1:0] wd_q;

   assign wd_fire = (wd_q == WD_LAST);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wd_q <= '0;
      end else if (state_n == LOAD) begin
         wd_q <= '0;
      end else if (state_q == WAIT_ACK || state_q == WAIT_DONE) begin
         wd_q <= wd_q + 1'b1;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT_CYCLES == 0);
   assign wd_fire    = 1'b0;
`endif

   always_comb begin
      state_n = state_q;
      tx_pop  = 1'b0;
      push_n  = 1'b0;
      to_set  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!tx_empty) begin
               state_n = LOAD;
               tx_pop  = 1'b1;
            end
         end
         LOAD: state_n = WAIT_ACK;
         WAIT_ACK: begin
            if (!bus.MDone) begin
               state_n = WAIT_DONE;
            end else if (wd_fire) begin
               to_set  = 1'b1;
               state_n = POST;
            end
         end
         WAIT_DONE: begin
            if (bus.MDone) begin
               push_n  = 1'b1;
               state_n = POST;
            end else if (wd_fire) begin
               to_set  = 1'b1;
               state_n = POST;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // RdData is a register tracking the RX head after this edge's
   // push/pop; it holds its value whenever the FIFO goes empty.
   always_comb begin
      rx_rp_nx = rx_rp + (FIFO_AW + 1)'(rx_pop);
      rx_wp_nx = rx_wp + (FIFO_AW + 1)'(rx_push);
      rd_nx    = rd_q;
      if (rx_rp_nx != rx_wp_nx) begin
         if (rx_push &&
             rx_rp_nx[FIFO_AW-1:0] == rx_wp[FIFO_AW-1:0])
            rd_nx = rx_word_q;
         else
            rd_nx = rx_mem[rx_rp_nx[FIFO_AW-1:0]];
      end
   end

   always_ff @(posedge Clk) begin
      if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= bus.WrData;
      if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_word_q;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         tx_wp     <= '0;
         tx_rp     <= '0;
         rx_wp     <= '0;
         rx_rp     <= '0;
         rx_push_q <= 1'b0;
         rx_word_q <= '0;
         rd_q      <= '0;
         mtx_q     <= '0;
         mstart_q  <= 1'b0;
         gap_q     <= '0;
         tx_ovf_q  <= 1'b0;
         rx_ovf_q  <= 1'b0;
         to_q      <= 1'b0;
      end else begin
         state_q  <= state_n;
         tx_wp    <= tx_wp + (FIFO_AW + 1)'(tx_push);
         tx_rp    <= tx_rp + (FIFO_AW + 1)'(tx_pop);
         rx_wp    <= rx_wp_nx;
         rx_rp    <= rx_rp_nx;
         rd_q     <= rd_nx;
         mstart_q <= (state_n == LOAD);
         if (tx_pop) mtx_q <= tx_mem[tx_rp[FIFO_AW-1:0]];
         // Received word lands in the RX FIFO one edge after Done.
         rx_push_q <= push_n;
         if (push_n) rx_word_q <= bus.MRxData;
         gap_q    <= (state_q == GAP) ? gap_q + 1'b1 : '0;
         tx_ovf_q <= (bus.WrEn && tx_full && !tx_pop) ||
                     (tx_ovf_q && !bus.ClrErr);
         rx_ovf_q <= (rx_push_q && rx_full && !rx_pop) ||
                     (rx_ovf_q && !bus.ClrErr);
         to_q     <= to_set || (to_q && !bus.ClrErr);
      end
   end

   assign bus.TxFull  = tx_full;
   assign bus.RdData  = rd_q;
   assign bus.RxEmpty = rx_empty;
   assign bus.Busy    = !tx_empty || (state_q != IDLE);
   assign bus.TxOvf   = tx_ovf_q;
   assign bus.RxOvf   = rx_ovf_q;
   assign bus.Timeout = to_q;
   assign bus.MStart  = mstart_q;
   assign bus.MTxData = mtx_q;
endmodule

// File: tb/tb_spi_xfer_queue.sv
// tb_spi_xfer_queue: randomized scenarios against a queue-based model
// of host writes, master echo (~TxData) and RX delivery.
module tb_spi_xfer_queue;
   localparam int DW  = 8;
   localparam int GAP = 2;
   localparam int TO  = 16;

   logic Clk = 1'b0;
   logic Reset_n = 1'b1;
   always #5 Clk = ~Clk;

   spi_xfer_queue_if #(.DATA_WIDTH(DW)) bus ();

   spi_xfer_queue #(
      .DATA_WIDTH(DW), .FIFO_AW(2),
      .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   logic [7:0] mlog[$];
   logic [7:0] wq[$];
   logic [7:0] acc[$];
   int  m_lat = 20;
   bit  m_stuck = 0;
   bit  m_kill = 0;
   int  last_done = -100;
   int  min_gap = 1000;
   int  mstart_hi = 0;
   bit  saw_to = 0;

   always @(negedge Clk) begin
      if (bus.MStart === 1'b1) mstart_hi <= mstart_hi + 1;
      if (bus.Timeout === 1'b1) saw_to <= 1'b1;
   end

   // SPI master model: Done drops the cycle after Start, rises m_lat
   // cycles later with the inverted transmit word.
   initial begin : master
      logic [7:0] w;
      bus.MDone   = 1'b1;
      bus.MRxData = '0;
      forever begin
         @(negedge Clk);
         if (Reset_n && bus.MStart === 1'b1) begin
            w = bus.MTxData;
            mlog.push_back(w);
            if (cyc - last_done - 1 < min_gap)
               min_gap = cyc - last_done - 1;
            if (!m_stuck) begin
               @(negedge Clk);
               bus.MDone = 1'b0;
               for (int i = 0; i < m_lat && !m_kill; i++)
                  @(negedge Clk);
               bus.MRxData = ~w;
               bus.MDone   = 1'b1;
               last_done   = cyc;
            end
         end
      end
   end

   task automatic push1(input logic [7:0] d);
      @(negedge Clk);
      bus.WrEn   = 1'b1;
      bus.WrData = d;
      @(posedge Clk);
      #1;
      bus.WrEn = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge Clk);
         #1;
         if (!bus.Busy) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (2) @(posedge Clk);
      #1;
   endtask

   task automatic wait_mdone(input logic v, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge Clk);
         #1;
         if (bus.MDone === v) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      bus.WrEn = 0; bus.WrData = 0; bus.RdEn = 0; bus.ClrErr = 0;
      #2 Reset_n = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checks++;
      if ({bus.TxFull, bus.RxEmpty, bus.Busy, bus.TxOvf, bus.RxOvf,
           bus.Timeout, bus.MStart} !== 7'b0100000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 0100000",
            {bus.TxFull, bus.RxEmpty, bus.Busy, bus.TxOvf, bus.RxOvf,
             bus.Timeout, bus.MStart});
      end
      checks++;
      if (bus.MTxData !== 8'h00 || bus.RdData !== 8'h00) begin
         errors++;
         $display("FAIL reset_data got %h/%h exp 00/00",
            bus.MTxData, bus.RdData);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   task automatic test_single;
      bit ok;
      int n0;
      n0 = mlog.size();
      m_lat = 20;
      push1(8'hA5);
      checks++;
      if (bus.MStart !== 1'b0 || bus.Busy !== 1'b1) begin
         errors++;
         $display("FAIL single_edgeN got mstart %b busy %b exp 0 1",
            bus.MStart, bus.Busy);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (bus.MStart !== 1'b1 || bus.MTxData !== 8'hA5) begin
         errors++;
         $display("FAIL single_launch got %b %h exp 1 a5",
            bus.MStart, bus.MTxData);
      end
      wait_mdone(1'b0, 20, ok);
      if (ok) wait_mdone(1'b1, 60, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_mdone got no handshake exp done");
      end
      checks++;
      if (bus.RxEmpty !== 1'b1) begin
         errors++;
         $display("FAIL single_rx_edgeM got %b exp 1", bus.RxEmpty);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (bus.RxEmpty !== 1'b0 || bus.RdData !== 8'h5A) begin
         errors++;
         $display("FAIL single_rx_edgeM1 got %b %h exp 0 5a",
            bus.RxEmpty, bus.RdData);
      end
      wait_idle(100, ok);
      checks++;
      if (!ok || bus.Busy !== 1'b0 || mlog.size() != n0 + 1) begin
         errors++;
         $display("FAIL single_idle got busy %b pulses %0d exp 0 %0d",
            bus.Busy, mlog.size() - n0, 1);
      end
      @(negedge Clk);
      bus.RdEn = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      bus.RdEn = 1'b0;
      checks++;
      if (bus.RxEmpty !== 1'b1 || bus.RdData !== 8'h5A) begin
         errors++;
         $display("FAIL single_rd_empty got %b %h exp 1 5a",
            bus.RxEmpty, bus.RdData);
      end
   endtask

   task automatic test_burst;
      bit ok;
      int n0;
      wq = {8'h01, 8'h02, 8'h03, 8'h04};
      n0 = mlog.size();
      min_gap = 1000;
      m_lat = $urandom_range(5, 15);
      foreach (wq[i]) push1(wq[i]);
      wait_idle(500, ok);
      checks++;
      if (!ok || mlog.size() != n0 + 4) begin
         errors++;
         $display("FAIL burst_pulses got %0d exp 4", mlog.size() - n0);
      end
      for (int i = 0; i < 4 && n0 + i < mlog.size(); i++) begin
         checks++;
         if (mlog[n0+i] !== wq[i]) begin
            errors++;
            $display("FAIL burst_tx[%0d] got %h exp %h",
               i, mlog[n0+i], wq[i]);
         end
      end
      checks++;
      if (min_gap < GAP || mstart_hi != mlog.size()) begin
         errors++;
         $display("FAIL burst_gap got gap %0d hi %0d exp >=%0d %0d",
            min_gap, mstart_hi, GAP, mlog.size());
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         checks++;
         if (bus.RxEmpty !== 1'b0 || bus.RdData !== ~wq[i]) begin
            errors++;
            $display("FAIL burst_rx[%0d] got %h exp %h",
               i, bus.RdData, ~wq[i]);
         end
         bus.RdEn = 1'b1;
      end
      @(negedge Clk);
      bus.RdEn = 1'b0;
      checks++;
      if (bus.RxEmpty !== 1'b1) begin
         errors++;
         $display("FAIL burst_drain got %b exp 1", bus.RxEmpty);
      end
   endtask

   task automatic test_random;
      bit ok;
      int n0, n;
      for (int r = 0; r < 6; r++) begin
         wq.delete();
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
         m_lat = $urandom_range(1, 12);
         n0 = mlog.size();
         foreach (wq[i]) begin
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            push1(wq[i]);
         end
         wait_idle(600, ok);
         checks++;
         if (!ok || mlog.size() != n0 + n) begin
            errors++;
            $display("FAIL rand%0d_pulses got %0d exp %0d",
               r, mlog.size() - n0, n);
         end
         for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            checks++;
            if (bus.RxEmpty !== 1'b0 || bus.RdData !== ~wq[i] ||
                n0 + i >= mlog.size() || mlog[n0+i] !== wq[i]) begin
               errors++;
               $display("FAIL rand%0d_word[%0d] got rx %h exp %h",
                  r, i, bus.RdData, ~wq[i]);
            end
            bus.RdEn = 1'b1;
         end
         @(negedge Clk);
         bus.RdEn = 1'b0;
         checks++;
         if (bus.RxEmpty !== 1'b1 || bus.TxOvf !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d_end got empty %b ovf %b exp 1 0",
               r, bus.RxEmpty, bus.TxOvf);
         end
      end
   endtask

   task automatic test_tx_overflow;
      bit ok;
      logic [7:0] w;
      acc.delete();
      m_lat = 40;
      for (int i = 0; i < 7; i++) begin
         w = 8'($urandom);
         wq[i] = w;
      end
      push1(wq[0]);
      acc.push_back(wq[0]);
      wait_mdone(1'b0, 20, ok);
      for (int i = 1; i < 5; i++) begin
         push1(wq[i]);
         acc.push_back(wq[i]);
      end
      checks++;
      if (!ok || bus.TxFull !== 1'b1 || bus.TxOvf !== 1'b0) begin
         errors++;
         $display("FAIL txovf_full got full %b ovf %b exp 1 0",
            bus.TxFull, bus.TxOvf);
      end
      push1(wq[5]);
      checks++;
      if (bus.TxOvf !== 1'b1 || bus.TxFull !== 1'b1) begin
         errors++;
         $display("FAIL txovf_set got ovf %b full %b exp 1 1",
            bus.TxOvf, bus.TxFull);
      end
      bus.ClrErr = 1'b1;
      push1(wq[6]);
      bus.ClrErr = 1'b0;
      checks++;
      if (bus.TxOvf !== 1'b1) begin
         errors++;
         $display("FAIL txovf_setwins got %b exp 1", bus.TxOvf);
      end
      @(negedge Clk);
      bus.ClrErr = 1'b1;
      @(negedge Clk);
      bus.ClrErr = 1'b0;
      checks++;
      if (bus.TxOvf !== 1'b0) begin
         errors++;
         $display("FAIL txovf_clr got %b exp 0", bus.TxOvf);
      end
   endtask

   task automatic test_rx_overflow;
      bit ok;
      int n0;
      n0 = mlog.size() - 1;
      wait_idle(1500, ok);
      checks++;
      if (!ok || bus.RxOvf !== 1'b1) begin
         errors++;
         $display("FAIL rxovf_set got %b exp 1", bus.RxOvf);
      end
      checks++;
      if (mlog.size() != n0 + 5) begin
         errors++;
         $display("FAIL rxovf_pulses got %0d exp 5", mlog.size() - n0);
      end
      for (int i = 0; i < 5 && n0 + i < mlog.size(); i++) begin
         checks++;
         if (mlog[n0+i] !== acc[i]) begin
            errors++;
            $display("FAIL rxovf_tx[%0d] got %h exp %h",
               i, mlog[n0+i], acc[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         checks++;
         if (bus.RxEmpty !== 1'b0 || bus.RdData !== ~acc[i]) begin
            errors++;
            $display("FAIL rxovf_rx[%0d] got %h exp %h",
               i, bus.RdData, ~acc[i]);
         end
         bus.RdEn = 1'b1;
      end
      @(negedge Clk);
      bus.RdEn   = 1'b0;
      bus.ClrErr = 1'b1;
      @(negedge Clk);
      bus.ClrErr = 1'b0;
      checks++;
      if (bus.RxEmpty !== 1'b1 || bus.RxOvf !== 1'b0) begin
         errors++;
         $display("FAIL rxovf_end got empty %b ovf %b exp 1 0",
            bus.RxEmpty, bus.RxOvf);
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      int n0;
      logic [7:0] w;
      m_lat = 60;
      push1(8'($urandom));
      wait_mdone(1'b0, 20, ok);
      push1(8'($urandom));
      @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      checks++;
      if (!ok || {bus.MStart, bus.TxFull, bus.RxEmpty, bus.Busy}
          !== 4'b0010) begin
         errors++;
         $display("FAIL rstmid_now got %b exp 0010",
            {bus.MStart, bus.TxFull, bus.RxEmpty, bus.Busy});
      end
      m_kill = 1'b1;
      repeat (3) @(negedge Clk);
      m_kill  = 1'b0;
      Reset_n = 1'b1;
      m_lat   = 8;
      n0 = mlog.size();
      w  = 8'($urandom);
      push1(w);
      wait_idle(300, ok);
      checks++;
      if (!ok || mlog.size() != n0 + 1 || mlog[mlog.size()-1] !== w) begin
         errors++;
         $display("FAIL rstmid_clean got %0d pulses exp 1 word %h",
            mlog.size() - n0, w);
      end
      @(negedge Clk);
      checks++;
      if (bus.RxEmpty !== 1'b0 || bus.RdData !== ~w) begin
         errors++;
         $display("FAIL rstmid_rx got %h exp %h", bus.RdData, ~w);
      end
      bus.RdEn = 1'b1;
      @(negedge Clk);
      bus.RdEn = 1'b0;
      checks++;
      if (bus.RxEmpty !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_drain got %b exp 1", bus.RxEmpty);
      end
   endtask

`ifdef SPI_XFER_TIMEOUT_EN
   task automatic test_timeout;
      bit ok;
      int n0, n;
      logic [7:0] t0, t1;
      t0 = 8'($urandom);
      t1 = 8'($urandom);
      m_stuck = 1'b1;
      n0 = mlog.size();
      push1(t0);
      @(posedge Clk);
      #1;
      push1(t1);
      n = 1;
      while (bus.Timeout !== 1'b1 && n < 40) begin
         @(posedge Clk);
         #1;
         n++;
      end
      checks++;
      if (n != TO + 1) begin
         errors++;
         $display("FAIL timeout_lat got %0d edges exp %0d", n, TO + 1);
      end
      checks++;
      if (bus.RxEmpty !== 1'b1) begin
         errors++;
         $display("FAIL timeout_rx got %b exp 1", bus.RxEmpty);
      end
      @(negedge Clk);
      bus.ClrErr = 1'b1;
      @(negedge Clk);
      bus.ClrErr = 1'b0;
      n = 0;
      while (mlog.size() < n0 + 2 && n < 40) begin
         @(posedge Clk);
         n++;
      end
      checks++;
      if (mlog.size() != n0 + 2 || mlog[mlog.size()-1] !== t1) begin
         errors++;
         $display("FAIL timeout_next got %0d launches exp 2 word %h",
            mlog.size() - n0, t1);
      end
      wait_idle(100, ok);
      checks++;
      if (!ok || bus.Timeout !== 1'b1 || bus.RxEmpty !== 1'b1) begin
         errors++;
         $display("FAIL timeout_second got to %b empty %b exp 1 1",
            bus.Timeout, bus.RxEmpty);
      end
      m_stuck = 1'b0;
      bus.ClrErr = 1'b1;
      @(negedge Clk);
      bus.ClrErr = 1'b0;
   endtask
`else
   task automatic test_timeout;
      checks++;
      if (saw_to !== 1'b0) begin
         errors++;
         $display("FAIL timeout_tied got %b exp 0", saw_to);
      end
   endtask
`endif

   initial begin
      #600000;
      $display("FAIL sim_timeout reached no end exp finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_random();
      test_tx_overflow();
      test_rx_overflow();
      test_reset_mid();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
